// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the serial receive path.
//   - uart_state_e : receiver FSM states
//   - OVERSAMPLE, MID_SAMPLE, DATA_BITS : frame timing constants
//   - calc_div()   : clkin cycles per oversampling tick
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    // Truncating division; callers must keep the result >= 2.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte delivery channel from the receiver to the CPU-side IO bus.
//   rx_data  : received byte
//   rx_valid : holding register full
//   rx_ready : consumer accepts the held byte
// Handshake: a byte transfers on every clkin edge where rx_valid and rx_ready
// are both 1. While rx_valid=1 and rx_ready=0 the producer keeps rx_data
// stable; rx_ready may be raised or lowered at any time.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversampling tick divider.
//   clkin : system clock
//   rst   : asynchronous active-low reset
//   run   : count enable; when 0 the count is held at 0
//   tick  : one-cycle strobe every DIV cycles of run
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clkin,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling and a one-entry
// valid/ready holding register.
//   clkin     : system clock
//   rst       : asynchronous active-low reset
//   clken     : receiver enable; 0 aborts any frame in progress
//   rxd       : asynchronous serial line, idle high
//   bus       : byte delivery channel (rx_data / rx_valid / rx_ready)
//   frame_err : one-cycle pulse, stop bit sampled 0
//   overrun   : one-cycle pulse, byte dropped because holding register full
//   busy      : FSM not in IDLE
//   state_dbg : current FSM state
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic          clkin,
    input  logic          rst,
    input  logic          clken,
    input  logic          rxd,
    uart_rx_if.master     bus,
    output logic          frame_err,
    output logic          overrun,
    output logic          busy,
    output uart_state_e   state_dbg
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);

    localparam logic [3:0] MID_S    = 4'(MID_SAMPLE);
    localparam logic [3:0] LAST_S   = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e          state;
    logic                 sync1, rxs, rxs_q;
    logic [3:0]           sample;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q, overrun_q;
    logic                 tick;

    // Two-stage synchronizer; rxs_q is only used to find the falling edge,
    // so a line that is already low when the receiver is enabled never
    // starts a frame mid-character.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_q <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
            rxs_q <= rxs;
        end
    end

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clkin (clkin),
        .rst   (rst),
        .run   (clken && (state != IDLE)),
        .tick  (tick)
    );

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sample      <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // Consumer side; a load below in the same cycle wins.
            if (valid_q && bus.rx_ready) begin
                valid_q <= 1'b0;
            end

            if (!clken) begin
                state   <= IDLE;
                sample  <= '0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        sample  <= '0;
                        bit_cnt <= '0;
                        if (rxs_q && !rxs) begin
                            state <= START;
                        end
                    end
                    START: begin
                        if (tick) begin
                            if (sample == MID_S) begin
                                // Sample counter restarts at mid start bit,
                                // so sample 15 lands mid-bit from here on.
                                sample <= '0;
                                state  <= rxs ? IDLE : DATA;
                            end else begin
                                sample <= sample + 4'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            sample <= sample + 4'd1;
                            if (sample == LAST_S) begin
                                shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == LAST_BIT) begin
                                    state <= STOP;
                                end
                            end
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            sample <= sample + 4'd1;
                            if (sample == LAST_S) begin
                                if (rxs) begin
                                    if (!valid_q || bus.rx_ready) begin
                                        data_q  <= shreg;
                                        valid_q <= 1'b1;
                                    end else begin
                                        overrun_q <= 1'b1;
                                    end
                                    state <= IDLE;
                                end else begin
                                    frame_err_q <= 1'b1;
                                    state       <= BREAK;
                                end
                            end
                        end
                    end
                    BREAK: begin
                        if (rxs) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rx_data  = data_q;
    assign bus.rx_valid = valid_q;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;
    assign busy         = (state != IDLE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; expected bytes and error events
// are queued as stimulus is issued and popped by a negedge monitor.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int BIT_CYC  = 160;
    localparam int EV_FERR  = 1;
    localparam int EV_OVR   = 2;

    // ---------------- clock / reset ----------------
    logic        clkin = 1'b0;
    logic        rst   = 1'b0;
    logic        clken = 1'b0;
    logic        rxd   = 1'b1;
    logic        frame_err, overrun, busy;
    uart_state_e state_dbg;

    uart_rx_if bus();

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clkin     (clkin),
        .rst       (rst),
        .clken     (clken),
        .rxd       (rxd),
        .bus       (bus),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clkin = ~clkin;

    // ---------------- scoreboard state ----------------
    int         n_cmp = 0;
    int         n_err = 0;
    int         valid_cycles = 0;
    logic [7:0] exp_q[$];
    int         evt_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic ev_check(input int code, input string name);
        if (evt_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: unexpected pulse, expected none (t=%0t)", name, $time);
        end else begin
            check(name, code, evt_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    // Leaves rxd at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        wait_cyc(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cyc(BIT_CYC);
        end
        rxd = stop_bit;
        wait_cyc(BIT_CYC);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clkin) begin
        if (rst) begin
            if (bus.rx_valid) valid_cycles++;
            if (bus.rx_valid && bus.rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rx_byte: got %02h, expected no byte (t=%0t)", bus.rx_data, $time);
                end else begin
                    check("rx_byte", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (frame_err) ev_check(EV_FERR, "frame_err");
            if (overrun)   ev_check(EV_OVR, "overrun");
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.rx_ready = 1'b0;
        wait_cyc(3);

        // Reset state
        check("rst_valid", bus.rx_valid, 0);
        check("rst_data", bus.rx_data, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state_dbg, IDLE);

        rst   = 1'b1;
        clken = 1'b1;
        wait_cyc(20);

        // 0x55 with consumer always ready: one-cycle valid pulse
        bus.rx_ready = 1'b1;
        valid_cycles = 0;
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            begin
                wait_cyc(800);
                check("busy_mid", busy, 1);
            end
        join
        wait_cyc(20);
        check("valid_pulse", valid_cycles, 1);
        check("busy_end", busy, 0);
        check("state_end", state_dbg, IDLE);

        // 0xA3 then 0x3C with consumer stalled: overrun on the second
        bus.rx_ready = 1'b0;
        exp_q.push_back(8'hA3);
        evt_q.push_back(EV_OVR);
        send_frame(8'hA3, 1'b1);
        wait_cyc(20);
        send_frame(8'h3C, 1'b1);
        wait_cyc(20);
        check("ovr_valid", bus.rx_valid, 1);
        check("ovr_data_kept", bus.rx_data, 8'hA3);
        bus.rx_ready = 1'b1;
        wait_cyc(3);
        check("ovr_valid_clr", bus.rx_valid, 0);
        check("ovr_drain", exp_q.size(), 0);

        // Ready rises exactly in the cycle of the second stop sample
        bus.rx_ready = 1'b0;
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1);
        wait_cyc(20);
        exp_q.push_back(8'h3C);
        fork
            send_frame(8'h3C, 1'b1);
            begin
                wait_cyc(1522);
                bus.rx_ready = 1'b1;
            end
        join
        wait_cyc(20);
        check("coinc_data", bus.rx_data, 8'h3C);
        check("coinc_valid_clr", bus.rx_valid, 0);
        check("coinc_drain", exp_q.size(), 0);

        // 40-cycle low glitch: rejected at the start-bit sample
        valid_cycles = 0;
        rxd = 1'b0;
        wait_cyc(20);
        check("glitch_busy", busy, 1);
        wait_cyc(20);
        rxd = 1'b1;
        wait_cyc(200);
        check("glitch_state", state_dbg, IDLE);
        check("glitch_no_valid", valid_cycles, 0);

        // 0x81 with a 0 stop bit and held-low line, then a good 0x7E
        evt_q.push_back(EV_FERR);
        send_frame(8'h81, 1'b0);
        wait_cyc(500);
        check("brk_state", state_dbg, BREAK);
        check("brk_no_valid", bus.rx_valid, 0);
        rxd = 1'b1;
        wait_cyc(5);
        check("brk_exit", state_dbg, IDLE);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        wait_cyc(20);
        check("brk_data", bus.rx_data, 8'h7E);
        check("brk_drain", exp_q.size(), 0);

        // Async reset in the middle of 0xFF: nothing delivered
        fork
            send_frame(8'hFF, 1'b1);
            begin
                wait_cyc(500);
                rst = 1'b0;
                #1;
                check("mid_rst_busy", busy, 0);
                check("mid_rst_state", state_dbg, IDLE);
                check("mid_rst_data", bus.rx_data, 0);
                wait_cyc(5);
                rst = 1'b1;
            end
        join
        wait_cyc(20);
        check("post_rst_state", state_dbg, IDLE);

        // clken dropped mid-frame of 0xF0 and raised while the line is high
        fork
            send_frame(8'hF0, 1'b1);
            begin
                wait_cyc(300);
                clken = 1'b0;
                wait_cyc(2);
                check("abort_busy", busy, 0);
                wait_cyc(598);
                clken = 1'b1;
            end
        join
        wait_cyc(20);
        check("abort_state", state_dbg, IDLE);
        check("abort_no_valid", bus.rx_valid, 0);

        // Clean frame afterwards
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        wait_cyc(20);
        check("final_data", bus.rx_data, 8'h12);
        check("final_exp_q", exp_q.size(), 0);
        check("final_evt_q", evt_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
